jelly_param_update_shadow: RTL
==============================

JELLY_PARAM_UPDATE_SHADOW -- requirements
Module: jelly_param_update_shadow

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of parameter words latched per update.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each parameter word.
REQ-003 SHALL have parameter INDEX_WIDTH, default 1, width of the update counter.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, request synchronizer depth; legal range is 2..4.
REQ-005 SHALL have parameter INIT_DATA, default all zeros, CHANNELS*DATA_WIDTH reset value of out_data.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-008 SHALL have port cke, input, 1 bit, clock enable for the apply logic.
REQ-009 SHALL have port in_trigger, input, 1 bit, apply point (e.g. frame start).
REQ-010 SHALL have port in_update_req, input, 1 bit, request toggle from the master clock domain.
REQ-011 SHALL have port in_data, input, CHANNELS*DATA_WIDTH bits, quasi-static parameters; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port out_update_ack, output, 1 bit, acknowledge toggle returned to the master.
REQ-013 SHALL have port out_pending, output, 1 bit, high while a request is waiting for a trigger.
REQ-014 SHALL have port out_update, output, 1 bit, registered flag that is high for the cke cycle following an apply.
REQ-015 SHALL have port out_index, output, INDEX_WIDTH bits, count of applies.
REQ-016 SHALL have port out_data, output, CHANNELS*DATA_WIDTH bits, shadow parameter registers.

Function
REQ-017 SHALL pass in_update_req through a SYNC_STAGES flop chain marked ASYNC_REG, clocked every edge regardless of cke.
REQ-018 SHALL register the last synchronizer stage into req_prev every edge.
REQ-019 SHALL define req_edge as (last stage XOR req_prev); when req_edge is high, pending SHALL be set at the next edge.
REQ-020 SHALL define apply as (cke & in_trigger & pending).
REQ-021 On apply, SHALL copy in_data into out_data for all channels in the same edge.
REQ-022 On apply, SHALL increment out_index by 1 with modulo 2^INDEX_WIDTH wrap-around.
REQ-023 On apply, SHALL set out_update_ack to the value of req_prev.
REQ-024 On apply, SHALL clear pending unless req_edge is high in the same cycle, in which case pending SHALL remain 1 because set wins.
REQ-025 SHALL update out_update (out_update <= apply) only on edges with cke=1, and SHALL hold it while cke=0.
REQ-026 Latency: for an in_update_req toggle set up before edge 1, pending SHALL be 1 after edge SYNC_STAGES+1, and the earliest apply edge SHALL be SYNC_STAGES+2.
REQ-027 A trigger with pending=0 SHALL leave out_data, out_index and out_update_ack unchanged, and SHALL give out_update=0.
REQ-028 Two request toggles arriving before an apply SHALL collapse into one apply; out_update_ack SHALL equal the final req_prev value.
REQ-029 Master protocol: in_data SHALL be held stable from its request toggle until out_update_ack equals the request level; in_data SHALL be a timing false path.
REQ-030 With cke=0, synchronization and pending SHALL still advance, and no apply SHALL occur.
REQ-031 out_pending SHALL be the pending register directly.

Reset
REQ-032 While reset=1 at an edge, SHALL clear the synchronizer flops, req_prev, pending, out_update_ack, out_update and out_index to 0.
REQ-033 While reset=1 at an edge, SHALL load out_data with INIT_DATA.
REQ-034 Reset asserted mid-request SHALL discard the pending request and any request in flight in the synchronizer.
REQ-035 After reset, an in_update_req held at 1 SHALL be detected as one edge, and out_update_ack SHALL become 1 after the next apply.

Verification
REQ-036 Basic: CHANNELS=4, SYNC_STAGES=2; in_data=0x11/22/33/44; toggle req 0->1; pulse trigger at edge 6 -> out_data = 0x11/22/33/44, out_index=1, ack=1, out_update=1 for one cycle.
REQ-037 Early trigger: toggle req; trigger at edge 3 -> no apply, pending=1; trigger at edge 4 -> apply.
REQ-038 cke stall: pending=1, trigger=1, cke=0 for 5 cycles -> no change; cke=1 -> apply on that edge.
REQ-039 Collapse: two req toggles 1 cycle apart (1->0), then trigger -> one apply, index +1, ack=0; simultaneous edge with apply -> pending stays 1.
REQ-040 Wrap and reset: INDEX_WIDTH=2, four applies -> index 3->0; assert reset with pending=1 -> pending=0, out_data=INIT_DATA.

Source files
------------

// File: rtl/jelly_param_update_shadow.sv
// rtl/jelly_param_update_shadow.sv - shadow parameter registers applied at a trigger after a toggle request handshake
module jelly_param_update_shadow #(
    parameter int                                 CHANNELS    = 4,
    parameter int                                 DATA_WIDTH  = 32,
    parameter int                                 INDEX_WIDTH = 1,
    parameter int                                 SYNC_STAGES = 2,
    parameter logic [CHANNELS*DATA_WIDTH-1:0]     INIT_DATA   = '0
) (
    input  logic                                  reset,
    input  logic                                  clk,
    input  logic                                  cke,
    input  logic                                  in_trigger,
    input  logic                                  in_update_req,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        in_data,
    output logic                                  out_update_ack,
    output logic                                  out_pending,
    output logic                                  out_update,
    output logic [INDEX_WIDTH-1:0]                out_index,
    output logic [CHANNELS*DATA_WIDTH-1:0]        out_data
);

    // Request toggle crosses from the master domain; runs every edge, independent of cke.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_ff;
    logic                                   req_prev;
    logic                                   pending;
    logic                                   req_edge;
    logic                                   apply;

    assign req_edge    = sync_ff[SYNC_STAGES-1] ^ req_prev;
    assign apply       = cke & in_trigger & pending;
    assign out_pending = pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff  <= '0;
            req_prev <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], in_update_req};
            req_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    // A new request edge wins over the clear caused by an apply in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (req_edge) begin
            pending <= 1'b1;
        end else if (apply) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data       <= INIT_DATA;
            out_index      <= '0;
            out_update_ack <= 1'b0;
        end else if (apply) begin
            out_data       <= in_data;
            out_index      <= out_index + INDEX_WIDTH'(1);
            out_update_ack <= req_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_update <= 1'b0;
        end else if (cke) begin
            out_update <= apply;
        end
    end

endmodule
